// File: rtl/mdu_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
// The master issues start/op/operands; the slave returns HI/LO, busy and the
// stall request consumed by the hazard unit.
interface mdu_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall_req;

    modport master (
        output start, op, d1, d2,
        input  hi, lo, busy, stall_req
    );

    modport slave (
        input  start, op, d1, d2,
        output hi, lo, busy, stall_req
    );
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed when the request is accepted and parked in pend_*;
// it is only copied into HI/LO once the busy window has elapsed, so the
// observable latency matches the iterative hardware this unit stands in for.
module mdu_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_unit_if.slave  bus
);
    localparam int CW = $clog2(DIV_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_reg;
    logic [CW-1:0]    count_reg;
    logic             busy_reg;
    logic             pend_wr_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] pend_hi_reg;
    logic [WIDTH-1:0] pend_lo_reg;

    // Shared multiplier: sign-extending to 2*WIDTH makes the low 2*WIDTH bits
    // of the product correct for both signed and unsigned operands.
    logic             mul_signed;
    logic [2*WIDTH-1:0] mul_a;
    logic [2*WIDTH-1:0] mul_b;
    logic [2*WIDTH-1:0] mul_full;

    assign mul_signed = (bus.op == OP_MULT);
    assign mul_a      = {{WIDTH{mul_signed & bus.d1[WIDTH-1]}}, bus.d1};
    assign mul_b      = {{WIDTH{mul_signed & bus.d2[WIDTH-1]}}, bus.d2};
    assign mul_full   = mul_a * mul_b;

    // Divider works on magnitudes and restores signs afterwards. This keeps
    // INT_MIN / -1 well defined (quotient wraps to INT_MIN, remainder 0)
    // instead of relying on signed-division overflow semantics.
    logic             div_signed;
    logic             a_neg;
    logic             b_neg;
    logic             div_zero;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] uq;
    logic [WIDTH-1:0] ur;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;

    // Signed/unsigned quotient and remainder from the current operands.
    always_comb begin
        div_signed = (bus.op == OP_DIV);
        a_neg      = div_signed & bus.d1[WIDTH-1];
        b_neg      = div_signed & bus.d2[WIDTH-1];
        div_zero   = (bus.d2 == '0);
        mag_a      = a_neg ? (~bus.d1 + WIDTH'(1)) : bus.d1;
        mag_b      = b_neg ? (~bus.d2 + WIDTH'(1)) : bus.d2;
        uq         = '0;
        ur         = '0;
        if (!div_zero) begin
            uq = mag_a / mag_b;
            ur = mag_a % mag_b;
        end
        div_q = (a_neg ^ b_neg) ? (~uq + WIDTH'(1)) : uq;
        div_r = a_neg ? (~ur + WIDTH'(1)) : ur;
    end

    // Control FSM: accepts requests in IDLE, counts the busy window in RUN
    // and commits the parked result on the last busy cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            busy_reg    <= 1'b0;
            pend_wr_reg <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            pend_hi_reg <= '0;
            pend_lo_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU: begin
                                pend_hi_reg <= mul_full[2*WIDTH-1:WIDTH];
                                pend_lo_reg <= mul_full[WIDTH-1:0];
                                pend_wr_reg <= 1'b1;
                                count_reg   <= CW'(MUL_CYCLES);
                                busy_reg    <= 1'b1;
                                state_reg   <= RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                // Divide by zero still burns the full window
                                // but leaves HI/LO untouched at commit.
                                pend_hi_reg <= div_r;
                                pend_lo_reg <= div_q;
                                pend_wr_reg <= !div_zero;
                                count_reg   <= CW'(DIV_CYCLES);
                                busy_reg    <= 1'b1;
                                state_reg   <= RUN;
                            end
                            OP_MTHI: hi_reg <= bus.d1;
                            OP_MTLO: lo_reg <= bus.d1;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    count_reg <= count_reg - CW'(1);
                    if (count_reg == CW'(1)) begin
                        if (pend_wr_reg) begin
                            hi_reg <= pend_hi_reg;
                            lo_reg <= pend_lo_reg;
                        end
                        pend_wr_reg <= 1'b0;
                        busy_reg    <= 1'b0;
                        state_reg   <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hi        = hi_reg;
    assign bus.lo        = lo_reg;
    assign bus.busy      = busy_reg;
    // Combinational so the hazard unit can freeze the pipeline in the very
    // cycle a multi-cycle op is issued.
    assign bus.stall_req = busy_reg |
                           (bus.start & (bus.op >= OP_MULT) & (bus.op <= OP_DIVU));
endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: a vector table for the arithmetic cases plus
// hand-written sequences for mt ops, divide by zero, back-to-back issue,
// requests during busy and reset in mid-operation.
module tb_mdu_unit;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    mdu_unit_if #(.WIDTH(32)) bus ();

    mdu_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    // Drive a one-cycle request at the current negedge; returns stall_req
    // as seen during the request cycle. Ends on the following negedge.
    task automatic issue(input logic [2:0] op, input logic [31:0] d1,
                         input logic [31:0] d2, output logic stall);
        bus.start = 1'b1;
        bus.op    = op;
        bus.d1    = d1;
        bus.d2    = d2;
        #1;
        stall = bus.stall_req;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 3'd0;
    endtask

    // Count consecutive busy cycles from the current negedge; bounded.
    task automatic run_busy(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic st;
        int   n;

        vecs[0] = '{"mult -3*7",        3'd1, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 5};
        vecs[1] = '{"multu FFFFFFFF*2", 3'd2, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 5};
        vecs[2] = '{"div -7/2",         3'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3] = '{"div INT_MIN/-1",   3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
        vecs[4] = '{"divu 100/7",       3'd4, 32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E, 10};
        vecs[5] = '{"mult max*max",     3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 5};
        vecs[6] = '{"div 7/-2",         3'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
        vecs[7] = '{"multu 2^31*2^31",  3'd2, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};

        tests = 0;
        fails = 0;
        clk = 1'b0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.op = 3'd0;
        bus.d1 = '0;
        bus.d2 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset hi", bus.hi, 32'h0);
        check("reset lo", bus.lo, 32'h0);
        check("reset busy", 32'(bus.busy), 32'h0);
        check("reset stall", 32'(bus.stall_req), 32'h0);

        // Table-driven arithmetic vectors.
        foreach (vecs[i]) begin
            @(negedge clk);
            issue(vecs[i].op, vecs[i].d1, vecs[i].d2, st);
            check({vecs[i].name, " stall"}, 32'(st), 32'h1);
            run_busy(n);
            check({vecs[i].name, " cycles"}, 32'(n), 32'(vecs[i].cycles));
            check({vecs[i].name, " hi"}, bus.hi, vecs[i].hi);
            check({vecs[i].name, " lo"}, bus.lo, vecs[i].lo);
        end

        // op 0 and op 7 do nothing (last result: hi=40000000 lo=0).
        issue(3'd0, 32'h1111, 32'h2222, st);
        check("op0 stall", 32'(st), 32'h0);
        check("op0 busy", 32'(bus.busy), 32'h0);
        issue(3'd7, 32'h1111, 32'h2222, st);
        check("op7 busy", 32'(bus.busy), 32'h0);
        check("op7 hi", bus.hi, 32'h4000_0000);
        check("op7 lo", bus.lo, 32'h0);

        // mthi/mtlo then divide by zero leaves HI/LO untouched.
        issue(3'd5, 32'h1234, 32'h0, st);
        check("mthi stall", 32'(st), 32'h0);
        check("mthi busy", 32'(bus.busy), 32'h0);
        check("mthi hi", bus.hi, 32'h1234);
        issue(3'd6, 32'h5678, 32'h0, st);
        check("mtlo lo", bus.lo, 32'h5678);
        issue(3'd4, 32'd7, 32'd0, st);
        run_busy(n);
        check("divu/0 cycles", 32'(n), 32'd10);
        check("divu/0 hi", bus.hi, 32'h1234);
        check("divu/0 lo", bus.lo, 32'h5678);

        // Back-to-back: second start in the first idle cycle.
        issue(3'd1, 32'hFFFF_FFFD, 32'd7, st);
        run_busy(n);
        check("b2b first hi", bus.hi, 32'hFFFF_FFFF);
        check("b2b first lo", bus.lo, 32'hFFFF_FFEB);
        issue(3'd2, 32'hFFFF_FFFF, 32'd2, st);
        check("b2b second stall", 32'(st), 32'h1);
        run_busy(n);
        check("b2b second cycles", 32'(n), 32'd5);
        check("b2b second hi", bus.hi, 32'h1);
        check("b2b second lo", bus.lo, 32'hFFFF_FFFE);

        // mtlo issued during busy must be ignored.
        issue(3'd2, 32'd3, 32'd4, st);
        @(negedge clk);
        issue(3'd6, 32'hAAAA, 32'h0, st);
        check("mtlo-in-busy lo", bus.lo, 32'hFFFF_FFFE);
        check("mtlo-in-busy busy", 32'(bus.busy), 32'h1);
        run_busy(n);
        check("mtlo-in-busy rest", 32'(n), 32'd3);
        check("mtlo-in-busy final hi", bus.hi, 32'h0);
        check("mtlo-in-busy final lo", bus.lo, 32'd12);

        // Reset in busy cycle 3 discards the pending product.
        issue(3'd5, 32'h55, 32'h0, st);
        issue(3'd1, 32'd6, 32'd7, st);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset busy", 32'(bus.busy), 32'h0);
        check("midreset hi", bus.hi, 32'h0);
        check("midreset lo", bus.lo, 32'h0);
        repeat (8) @(negedge clk);
        check("midreset later lo", bus.lo, 32'h0);
        check("midreset later busy", 32'(bus.busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
